// File: rtl/contador_param_sinc.sv
// contador_param_sinc: WIDTH-bit synchronous +1/-1/-3/load counter built from nibble slices with registered per-nibble carry flags; define COUNTER_SAT_EN for saturating arithmetic
module contador_param_sinc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enb,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic [WIDTH/4-1:0] nib_co
);
  localparam int NIB = WIDTH / 4;
  if (WIDTH % 4 != 0 || WIDTH < 4) begin : g_bad
    $error("contador_param_sinc: WIDTH must be a multiple of 4 and >= 4");
  end
  logic             sub;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] r;
  logic [NIB:0]     c;
  assign sub  = modo != 2'b00;
  assign k    = modo[1] ? WIDTH'(3) : WIDTH'(1);
  assign c[0] = 1'b0;
  for (genvar i = 0; i < NIB; i++) begin : g_nib
    logic [4:0] s;
    assign s = sub ? {1'b0, Q[4*i+:4]} - {1'b0, k[4*i+:4]} - {4'b0, c[i]}
                   : {1'b0, Q[4*i+:4]} + {1'b0, k[4*i+:4]} + {4'b0, c[i]};
    assign r[4*i+:4] = s[3:0];
    assign c[i+1]    = s[4];
  end
  // counter state and flags for the update just taken
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      Q      <= '0;
      RCO    <= 1'b0;
      nib_co <= '0;
    end else if (!enb) begin
      RCO    <= 1'b0;
      nib_co <= '0;
    end else if (&modo) begin
      Q      <= D;
      RCO    <= 1'b0;
      nib_co <= '0;
    end
`ifdef COUNTER_SAT_EN
    else if (c[NIB]) begin
      Q      <= modo == 2'b00 ? '1 : '0;
      RCO    <= 1'b1;
      nib_co <= '0;
    end
`endif
    else begin
      Q      <= r;
      RCO    <= c[NIB];
      nib_co <= c[NIB:1];
    end
endmodule

// File: tb/tb_contador_param_sinc.sv
// tb_contador_param_sinc: randomized and directed check of 16- and 8-bit counters against an arithmetic reference model
module tb_contador_param_sinc;
  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic        enb = 1'b0;
  logic [1:0]  modo = 2'b00;
  logic [15:0] D = '0;
  logic [15:0] q16;
  logic        rco16;
  logic [3:0]  nco16;
  logic [7:0]  q8;
  logic        rco8;
  logic [1:0]  nco8;
  int n_tests = 0;
  int n_fail = 0;
  logic [63:0] e_q16, e_q8;
  logic        e_r16, e_r8;
  logic [15:0] e_c16, e_c8;

  contador_param_sinc #(.WIDTH(16)) dut16 (
    .clk(clk), .reset_L(reset_L), .enb(enb), .modo(modo), .D(D),
    .Q(q16), .RCO(rco16), .nib_co(nco16)
  );
  contador_param_sinc #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_L(reset_L), .enb(enb), .modo(modo), .D(D[7:0]),
    .Q(q8), .RCO(rco8), .nib_co(nco8)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_step(input int w, input logic [63:0] q, input logic en,
                                   input logic [1:0] m, input logic [63:0] d,
                                   output logic [63:0] nq, output logic rco, output logic [15:0] nco);
    longint unsigned mask, k, lim, low;
    logic add, ovf;
    mask = (64'd1 << w) - 1;
    nq = q;
    rco = 1'b0;
    nco = '0;
    if (!en) return;
    if (m == 2'b11) begin
      nq = d & mask;
      return;
    end
    k = m[1] ? 3 : 1;
    add = m == 2'b00;
    for (int i = 0; i < w / 4; i++) begin
      lim = 64'd1 << (4 * i + 4);
      low = q % lim;
      nco[i] = add ? (low + k >= lim) : (low < k);
    end
    ovf = add ? (q + k > mask) : (q < k);
`ifdef COUNTER_SAT_EN
    if (ovf) begin
      nq = add ? mask : 0;
      rco = 1'b1;
      nco = '0;
      return;
    end
`endif
    nq = add ? (q + k) & mask : (q - k) & mask;
    rco = ovf;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_q16"}, q16, e_q16);
    chk({tag, "_rco16"}, rco16, e_r16);
    chk({tag, "_nco16"}, nco16, e_c16);
    chk({tag, "_q8"}, q8, e_q8);
    chk({tag, "_rco8"}, rco8, e_r8);
    chk({tag, "_nco8"}, nco8, e_c8);
  endtask

  task automatic step(input string tag, input logic e, input logic [1:0] m, input logic [15:0] d);
    logic [63:0] nq16, nq8;
    logic r16, r8;
    logic [15:0] c16, c8;
    enb = e;
    modo = m;
    D = d;
    ref_step(16, e_q16, e, m, d, nq16, r16, c16);
    ref_step(8, e_q8, e, m, d, nq8, r8, c8);
    @(posedge clk);
    #1;
    e_q16 = nq16; e_r16 = r16; e_c16 = c16;
    e_q8 = nq8; e_r8 = r8; e_c8 = c8;
    check_all(tag);
  endtask

  task automatic mid_reset();
    #3 reset_L = 1'b0;
    #1;
    e_q16 = 0; e_r16 = 0; e_c16 = 0;
    e_q8 = 0; e_r8 = 0; e_c8 = 0;
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    #2 reset_L = 1'b1;
  endtask

  initial begin
    e_q16 = 0; e_r16 = 0; e_c16 = 0;
    e_q8 = 0; e_r8 = 0; e_c8 = 0;
    @(posedge clk);
    #1;
    check_all("reset");
    #2 reset_L = 1'b1;
    step("t1_load", 1'b1, 2'b11, 16'h0005);
    mid_reset();
    step("t1_inc", 1'b1, 2'b00, 16'h0000);
    chk("t1_q", q16, 16'h0001);
    step("t2_load", 1'b1, 2'b11, 16'hFFFE);
    step("t2_a", 1'b1, 2'b00, 16'h0000);
    step("t2_b", 1'b1, 2'b00, 16'h0000);
`ifndef COUNTER_SAT_EN
    chk("t2_q0", q16, 16'h0000);
    chk("t2_rco", rco16, 1'b1);
    chk("t2_nco", nco16, 4'b1111);
`endif
    step("t2_c", 1'b1, 2'b00, 16'h0000);
`ifndef COUNTER_SAT_EN
    chk("t2_q1", q16, 16'h0001);
    chk("t2_rco_off", rco16, 1'b0);
`endif
    step("t3_load", 1'b1, 2'b11, 16'h00F0);
    step("t3_dec", 1'b1, 2'b01, 16'h0000);
    chk("t3_q", q16, 16'h00EF);
    chk("t3_nco", nco16, 4'b0001);
    chk("t3_rco", rco16, 1'b0);
    step("t4_load", 1'b1, 2'b11, 16'h0002);
    step("t4_a", 1'b1, 2'b10, 16'h0000);
`ifndef COUNTER_SAT_EN
    chk("t4_q", q16, 16'hFFFF);
    chk("t4_rco", rco16, 1'b1);
    chk("t4_nco", nco16, 4'b1111);
`endif
    step("t4_b", 1'b1, 2'b10, 16'h0000);
`ifndef COUNTER_SAT_EN
    chk("t4_q2", q16, 16'hFFFC);
    chk("t4_rco2", rco16, 1'b0);
    chk("t4_nco2", nco16, 4'b0000);
`endif
    step("t5_load", 1'b1, 2'b11, 16'h00AA);
    for (int i = 0; i < 3; i++) begin
      step("t5_hold", 1'b0, 2'b11, 16'h1234);
      chk("t5_q", q16, 16'h00AA);
      chk("t5_rco", rco16, 1'b0);
    end
`ifdef COUNTER_SAT_EN
    step("t6_load", 1'b1, 2'b11, 16'hFFFF);
    for (int i = 0; i < 2; i++) begin
      step("t6_inc", 1'b1, 2'b00, 16'h0000);
      chk("t6_q", q16, 16'hFFFF);
      chk("t6_rco", rco16, 1'b1);
      chk("t6_nco", nco16, 4'b0000);
    end
    step("t6_load8", 1'b1, 2'b11, 16'h0001);
    step("t6_sub8", 1'b1, 2'b10, 16'h0000);
    chk("t6_q8", q8, 8'h00);
    chk("t6_rco8", rco8, 1'b1);
`endif
    for (int n = 0; n < 400; n++) begin
      logic [15:0] d;
      logic [1:0]  m;
      case ($urandom_range(0, 3))
        0: d = 16'hFFFF - 16'($urandom_range(0, 3));
        1: d = 16'($urandom_range(0, 3));
        default: d = 16'($urandom);
      endcase
      m = $urandom_range(0, 7) == 0 ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 60) == 0) mid_reset();
      step("rnd", $urandom_range(0, 9) != 0, m, d);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
